// File: rtl/branch_redirect_unit.sv
// rtl/branch_redirect_unit.sv - EX-stage branch decision, target generation, PC register and flush FSM
//
// Ports:
//   clk_i, rst_i            clock (rising edge), asynchronous active-high reset
//   stall_i                 holds the PC and the flush counter
//   ex_valid_i              EX slot holds a valid instruction
//   ex_is_br_i/jal_i/jalr_i control-transfer type flags (jalr > jal > br)
//   ex_funct3_i             branch condition encoding
//   ex_pc_i, ex_imm_i       PC and sign-extended immediate of the EX instruction
//   ex_rs1_i                JALR base register value
//   br_less_i, br_equal_i   comparator results
//   br_unsign_o             selects unsigned compare in the comparator (combinational)
//   pc_o                    fetch PC (registered)
//   redirect_o              one-cycle pulse: pc_o was just loaded with a target
//   flush_o                 squash IF/ID while high
//   misalign_o              one-cycle pulse: target[1] set, transfer suppressed
//   illegal_br_o            one-cycle pulse: reserved funct3 on a valid branch
//   taken_cnt_o             saturating count of redirects
module branch_redirect_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2,
    parameter int          CNT_W        = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             ex_valid_i,
    input  logic             ex_is_br_i,
    input  logic             ex_is_jal_i,
    input  logic             ex_is_jalr_i,
    input  logic [2:0]       ex_funct3_i,
    input  logic [31:0]      ex_pc_i,
    input  logic [31:0]      ex_imm_i,
    input  logic [31:0]      ex_rs1_i,
    input  logic             br_less_i,
    input  logic             br_equal_i,
    output logic             br_unsign_o,
    output logic [31:0]      pc_o,
    output logic             redirect_o,
    output logic             flush_o,
    output logic             misalign_o,
    output logic             illegal_br_o,
    output logic [CNT_W-1:0] taken_cnt_o
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

    state_t           state_q, state_d;
    logic [2:0]       fcnt_q, fcnt_d;
    logic [31:0]      pc_d;
    logic             redirect_d, flush_d, misalign_d, illegal_d;
    logic [CNT_W-1:0] cnt_d;

    logic        taken;
    logic        sel_jalr, sel_jal, sel_br;
    logic [31:0] sum_pc, sum_rs1, target, pc_seq;
    logic        run, xfer, illegal_hit;

    // funct3[1] distinguishes the unsigned compare pair (BLTU/BGEU).
    assign br_unsign_o = ex_funct3_i[1];

    always_comb begin
        taken = 1'b0;
        case (ex_funct3_i)
            3'b000:         taken = br_equal_i;
            3'b001:         taken = ~br_equal_i;
            3'b100, 3'b110: taken = br_less_i;
            3'b101, 3'b111: taken = ~br_less_i;
            default:        taken = 1'b0;
        endcase
    end

    // Only one type is honoured when several flags are set.
    assign sel_jalr = ex_is_jalr_i;
    assign sel_jal  = ~ex_is_jalr_i & ex_is_jal_i;
    assign sel_br   = ~ex_is_jalr_i & ~ex_is_jal_i & ex_is_br_i;

    assign sum_pc  = ex_pc_i + ex_imm_i;
    assign sum_rs1 = ex_rs1_i + ex_imm_i;
    assign target  = sel_jalr ? (sum_rs1 & ~32'h1) : sum_pc;

    assign run         = (state_q == RUN);
    assign xfer        = ex_valid_i & run & (sel_jalr | sel_jal | (sel_br & taken));
    assign illegal_hit = ex_valid_i & run & sel_br & (ex_funct3_i[2:1] == 2'b01);
    assign pc_seq      = stall_i ? pc_o : pc_o + 32'd4;

    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        pc_d       = pc_seq;
        redirect_d = 1'b0;
        misalign_d = 1'b0;
        illegal_d  = illegal_hit;
        cnt_d      = taken_cnt_o;
        case (state_q)
            RUN: begin
                if (xfer && target[1]) begin
                    misalign_d = 1'b1;
                end else if (xfer) begin
                    // A redirect wins over stall_i.
                    pc_d       = target;
                    redirect_d = 1'b1;
                    state_d    = FLUSH;
                    fcnt_d     = FLUSH_INIT;
                    if (taken_cnt_o != '1) begin
                        cnt_d = taken_cnt_o + CNT_W'(1);
                    end
                end
            end
            FLUSH: begin
                if (!stall_i) begin
                    if (fcnt_q == 3'd1) begin
                        state_d = RUN;
                        fcnt_d  = 3'd0;
                    end else begin
                        fcnt_d = fcnt_q - 3'd1;
                    end
                end
            end
            default: begin
                state_d = RUN;
                fcnt_d  = 3'd0;
            end
        endcase
        flush_d = (state_d == FLUSH);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= RUN;
            fcnt_q       <= 3'd0;
            pc_o         <= RESET_PC;
            redirect_o   <= 1'b0;
            flush_o      <= 1'b0;
            misalign_o   <= 1'b0;
            illegal_br_o <= 1'b0;
            taken_cnt_o  <= '0;
        end else begin
            state_q      <= state_d;
            fcnt_q       <= fcnt_d;
            pc_o         <= pc_d;
            redirect_o   <= redirect_d;
            flush_o      <= flush_d;
            misalign_o   <= misalign_d;
            illegal_br_o <= illegal_d;
            taken_cnt_o  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_redirect_unit.sv
// tb/tb_branch_redirect_unit.sv - self-checking bench for branch_redirect_unit
module tb_branch_redirect_unit;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam int          FC  = 2;
    localparam int          CW  = 4;
    localparam int          CNT_MAX = (1 << CW) - 1;

    logic          clk_i, rst_i, stall_i;
    logic          ex_valid_i, ex_is_br_i, ex_is_jal_i, ex_is_jalr_i;
    logic [2:0]    ex_funct3_i;
    logic [31:0]   ex_pc_i, ex_imm_i, ex_rs1_i;
    logic          br_less_i, br_equal_i;
    logic          br_unsign_o;
    logic [31:0]   pc_o;
    logic          redirect_o, flush_o, misalign_o, illegal_br_o;
    logic [CW-1:0] taken_cnt_o;

    branch_redirect_unit #(.RESET_PC(RPC), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .stall_i     (stall_i),
        .ex_valid_i  (ex_valid_i),
        .ex_is_br_i  (ex_is_br_i),
        .ex_is_jal_i (ex_is_jal_i),
        .ex_is_jalr_i(ex_is_jalr_i),
        .ex_funct3_i (ex_funct3_i),
        .ex_pc_i     (ex_pc_i),
        .ex_imm_i    (ex_imm_i),
        .ex_rs1_i    (ex_rs1_i),
        .br_less_i   (br_less_i),
        .br_equal_i  (br_equal_i),
        .br_unsign_o (br_unsign_o),
        .pc_o        (pc_o),
        .redirect_o  (redirect_o),
        .flush_o     (flush_o),
        .misalign_o  (misalign_o),
        .illegal_br_o(illegal_br_o),
        .taken_cnt_o (taken_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: PC, remaining flush cycles, redirect count, last pulses.
    logic [31:0] m_pc;
    int          m_fl;
    int          m_cnt;
    bit          m_red, m_mis, m_ill;

    function automatic bit ref_taken(input logic [2:0] f3, input bit lt, input bit eq);
        case (f3)
            3'd0:       return eq;   // BEQ
            3'd1:       return !eq;  // BNE
            3'd4, 3'd6: return lt;   // BLT / BLTU
            3'd5, 3'd7: return !lt;  // BGE / BGEU
            default:    return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = RPC; m_fl = 0; m_cnt = 0;
        m_red = 0; m_mis = 0; m_ill = 0;
    endtask

    task automatic model_step();
        logic [31:0] tgt;
        bit x;
        bit adv;
        m_red = 0; m_mis = 0; m_ill = 0;
        adv = 1; x = 0; tgt = '0;
        if (m_fl == 0) begin
            if (ex_valid_i) begin
                if (ex_is_jalr_i) begin
                    tgt = (ex_rs1_i + ex_imm_i) & 32'hFFFF_FFFE; x = 1;
                end else if (ex_is_jal_i) begin
                    tgt = ex_pc_i + ex_imm_i; x = 1;
                end else if (ex_is_br_i) begin
                    tgt = ex_pc_i + ex_imm_i;
                    x = ref_taken(ex_funct3_i, br_less_i, br_equal_i);
                    m_ill = (ex_funct3_i == 3'd2) || (ex_funct3_i == 3'd3);
                end
                if (x && tgt[1]) begin
                    m_mis = 1;
                end else if (x) begin
                    m_pc = tgt; m_red = 1; m_fl = FC; adv = 0;
                    if (m_cnt < CNT_MAX) m_cnt++;
                end
            end
        end else if (!stall_i) begin
            m_fl--;
        end
        if (adv && !stall_i) m_pc = m_pc + 32'd4;
    endtask

    task automatic drive(input bit v, input bit br, input bit jal, input bit jalr,
                         input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] rs1, input bit lt, input bit eq, input bit st);
        ex_valid_i = v; ex_is_br_i = br; ex_is_jal_i = jal; ex_is_jalr_i = jalr;
        ex_funct3_i = f3; ex_pc_i = pc; ex_imm_i = imm; ex_rs1_i = rs1;
        br_less_i = lt; br_equal_i = eq; stall_i = st;
    endtask

    task automatic idle(input bit st);
        drive(0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 0, 0, st);
    endtask

    task automatic step();
        #1;
        check("br_unsign", br_unsign_o, ex_funct3_i[1]);
        model_step();
        @(posedge clk_i);
        #1;
        check("pc", pc_o, m_pc);
        check("redirect", redirect_o, m_red);
        check("flush", flush_o, m_fl > 0);
        check("misalign", misalign_o, m_mis);
        check("illegal", illegal_br_o, m_ill);
        check("taken_cnt", taken_cnt_o, 32'(m_cnt));
    endtask

    // Reset asserted between edges must take effect immediately.
    task automatic async_reset();
        idle(0);
        #2;
        rst_i = 1'b1;
        #1;
        model_reset();
        check("rst_pc", pc_o, RPC);
        check("rst_flush", flush_o, 1'b0);
        check("rst_redirect", redirect_o, 1'b0);
        check("rst_cnt", taken_cnt_o, 32'd0);
        @(posedge clk_i);
        #2;
        rst_i = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        rst_i = 1'b1;
        idle(0);
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check("reset_pc", pc_o, RPC);
        check("reset_flush", flush_o, 1'b0);
        check("reset_misalign", misalign_o, 1'b0);
        check("reset_illegal", illegal_br_o, 1'b0);
        rst_i = 1'b0;
        check("pc_after_release", pc_o, 32'h100);
        repeat (3) step();
        check("free_run_pc", pc_o, 32'h10C);

        // BEQ taken
        drive(1, 1, 0, 0, 3'b000, 32'h200, 32'h40, 32'h0, 0, 1, 0);
        step();
        check("beq_pc", pc_o, 32'h240);
        check("beq_redirect", redirect_o, 1'b1);
        check("beq_cnt", taken_cnt_o, 32'd1);
        idle(0); step();
        check("beq_flush2", flush_o, 1'b1);
        idle(0); step();
        check("beq_flush_end", flush_o, 1'b0);

        // BNE with equal: not taken
        drive(1, 1, 0, 0, 3'b001, 32'h200, 32'h40, 32'h0, 0, 1, 0);
        step();
        check("bne_no_redirect", redirect_o, 1'b0);

        // BLTU taken, then BGE not taken on less
        drive(1, 1, 0, 0, 3'b110, 32'h500, 32'h80, 32'h0, 1, 0, 0);
        check("bltu_unsign", br_unsign_o, 1'b1);
        step();
        check("bltu_redirect", redirect_o, 1'b1);
        idle(0); step(); idle(0); step();
        drive(1, 1, 0, 0, 3'b101, 32'h500, 32'h80, 32'h0, 1, 0, 0);
        check("bge_unsign", br_unsign_o, 1'b0);
        step();

        // JALR cases: low bit cleared, target[1] decides misalignment
        drive(1, 0, 0, 1, 3'd0, 32'h0, 32'h3, 32'h1001, 0, 0, 0);
        step();
        check("jalr_pc", pc_o, 32'h1004);
        idle(0); step(); idle(0); step();
        drive(1, 0, 0, 1, 3'd0, 32'h0, 32'h2, 32'h1001, 0, 0, 0); step();
        drive(1, 0, 0, 1, 3'd0, 32'h0, 32'h2, 32'h1000, 0, 0, 0); step();
        drive(1, 0, 0, 1, 3'd0, 32'h0, 32'h6, 32'h1000, 0, 0, 0); step();
        check("jalr_misalign", misalign_o, 1'b1);

        // JAL during FLUSH ignored; stall inside FLUSH extends it
        drive(1, 0, 1, 0, 3'd0, 32'h800, 32'h100, 32'h0, 0, 0, 0); step();
        drive(1, 0, 1, 0, 3'd0, 32'h800, 32'h200, 32'h0, 0, 0, 0); step();
        check("jal_in_flush_ignored", redirect_o, 1'b0);
        repeat (3) begin idle(1); step(); end
        idle(0); step(); idle(0); step();

        // Reset in the middle of a flush
        drive(1, 0, 1, 0, 3'd0, 32'h300, 32'h20, 32'h0, 0, 0, 0); step();
        async_reset();

        // Counter saturation
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 1, 0, 3'd0, 32'h400, 32'h80, 32'h0, 0, 0, 0); step();
            repeat (3) begin idle(0); step(); end
        end
        check("cnt_saturated", taken_cnt_o, 32'd15);

        // Reserved funct3 on a branch
        drive(1, 1, 0, 0, 3'b010, 32'h600, 32'h40, 32'h0, 1, 1, 0); step();
        check("illegal_pulse", illegal_br_o, 1'b1);
        check("illegal_no_redirect", redirect_o, 1'b0);
        idle(0); step();

        // PC wrap through the top of the address space
        drive(1, 0, 1, 0, 3'd0, 32'hFFFF_FFF0, 32'h8, 32'h0, 0, 0, 0); step();
        repeat (3) begin idle(0); step(); end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit v, br, jal, jalr, lt, eq, st;
            logic [2:0] f3;
            logic [31:0] pc, imm, rs1;
            r = $urandom;
            v = (r[1:0] != 2'b00); br = r[2]; jal = (r[5:3] == 3'b000);
            jalr = (r[8:6] == 3'b000); lt = r[9]; eq = r[10];
            st = (r[13:11] == 3'b000); f3 = r[16:14];
            pc = $urandom & 32'hFFFF_FFFC;
            rs1 = $urandom;
            r = $urandom;
            imm = r[0] ? $urandom : {{22{r[12]}}, r[11:2]};
            drive(v, br, jal, jalr, f3, pc, imm, rs1, lt, eq, st);
            step();
            r = $urandom;
            if (r[7:0] == 8'd0) async_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
